// File: rtl/div_unit_if.sv
// Request/response bundle between EX control and the multi-cycle divide unit.
interface div_unit_if #(
   parameter int XLEN = 32
);
   logic            i_start;
   logic [1:0]      i_div_op;
   logic [XLEN-1:0] i_op_a;
   logic [XLEN-1:0] i_op_b;
   logic            i_kill;
   logic            o_ready;
   logic            o_valid;
   logic [XLEN-1:0] o_result;

   modport master (
      output i_start, i_div_op, i_op_a, i_op_b, i_kill,
      input  o_ready, o_valid, o_result
   );

   modport slave (
      input  i_start, i_div_op, i_op_a, i_op_b, i_kill,
      output o_ready, o_valid, o_result
   );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU: bit-serial restoring divider, one quotient bit per cycle.
// Division by zero and signed overflow finish in one cycle without iterating.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   div_unit_if.slave  bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Two's complement negate, wrapping at XLEN bits.
   function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   state_e          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic [XLEN-1:0] dvd_q, dvd_d;      // dividend shifts out the top, quotient shifts in below
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            valid_q, valid_d;
   logic            ready_q, ready_d;

   logic            signed_s, a_neg_s, b_neg_s, div_zero_s, ovf_s, qbit_s;
   logic [XLEN-1:0] mag_a_s, mag_b_s, rem_nx_s, quo_nx_s, fixed_s, special_s;
   logic [XLEN:0]   rem_sh_s, diff_s;

   // Operand decode at accept time and one restoring iteration on the live registers.
   always_comb begin
      signed_s   = ~bus.i_div_op[0];
      a_neg_s    = signed_s & bus.i_op_a[XLEN-1];
      b_neg_s    = signed_s & bus.i_op_b[XLEN-1];
      mag_a_s    = a_neg_s ? neg2(bus.i_op_a) : bus.i_op_a;
      mag_b_s    = b_neg_s ? neg2(bus.i_op_b) : bus.i_op_b;
      div_zero_s = (bus.i_op_b == {XLEN{1'b0}});
      ovf_s      = signed_s & (bus.i_op_a == {1'b1, {(XLEN-1){1'b0}}})
                            & (bus.i_op_b == {XLEN{1'b1}});
      if (div_zero_s) begin
         special_s = bus.i_div_op[1] ? bus.i_op_a : {XLEN{1'b1}};
      end else begin
         special_s = bus.i_div_op[1] ? {XLEN{1'b0}} : bus.i_op_a;
      end
      // Partial remainder is kept one bit wider so a large divisor never loses the shifted-out bit.
      rem_sh_s = {rem_q, dvd_q[XLEN-1]};
      diff_s   = rem_sh_s - {1'b0, dvs_q};
      qbit_s   = ~diff_s[XLEN];
      rem_nx_s = qbit_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
      quo_nx_s = {dvd_q[XLEN-2:0], qbit_s};
      if (op_q[1]) begin
         fixed_s = neg_rem_q ? neg2(rem_nx_s) : rem_nx_s;
      end else begin
         fixed_s = neg_quo_q ? neg2(quo_nx_s) : quo_nx_s;
      end
   end

   // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      valid_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_kill) begin
               state_d = S_IDLE;
            end else if (bus.i_start) begin
               op_d      = bus.i_div_op;
               neg_quo_d = a_neg_s ^ b_neg_s;
               neg_rem_d = a_neg_s;
               dvd_d     = mag_a_s;
               dvs_d     = mag_b_s;
               rem_d     = {XLEN{1'b0}};
               cnt_d     = {CW{1'b0}};
               if (div_zero_s || ovf_s) begin
                  result_d = special_s;
                  valid_d  = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (bus.i_kill) begin
               state_d = S_IDLE;
            end else begin
               dvd_d = quo_nx_s;
               rem_d = rem_nx_s;
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_q == CW'(XLEN-1)) begin
                  result_d = fixed_s;
                  valid_d  = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ready_d = (state_d == S_IDLE);
   end

   // State and datapath registers; async reset returns everything to the idle state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= 2'b00;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dvd_q     <= {XLEN{1'b0}};
         dvs_q     <= {XLEN{1'b0}};
         rem_q     <= {XLEN{1'b0}};
         cnt_q     <= {CW{1'b0}};
         result_q  <= {XLEN{1'b0}};
         valid_q   <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         ready_q   <= ready_d;
      end
   end

   assign bus.o_ready  = ready_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus kill/hazard/reset sequences.
module tb_div_unit;
   logic clk;
   logic rst_n;
   int   vec_cnt;
   int   miscmp;
   logic [31:0] last_res;

   div_unit_if #(.XLEN(32)) dif ();

   div_unit #(.XLEN(32)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          special;
      string       name;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Wait for o_valid, counting clock edges; lat enters with edges already elapsed.
   task automatic wait_valid(inout int lat, output bit got);
      got = 1'b0;
      while (!got && lat < 40) begin
         if (dif.o_valid === 1'b1) begin
            got = 1'b1;
         end else begin
            @(posedge clk);
            lat++;
            @(negedge clk);
         end
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit special, input string name);
      int lat;
      bit got;
      @(negedge clk);
      chk({name, " ready"}, {31'd0, dif.o_ready}, 32'd1);
      dif.i_start  = 1'b1;
      dif.i_div_op = op;
      dif.i_op_a   = a;
      dif.i_op_b   = b;
      @(posedge clk);
      @(negedge clk);
      dif.i_start = 1'b0;
      lat = 0;
      wait_valid(lat, got);
      chk({name, " valid seen"}, {31'd0, got}, 32'd1);
      chk({name, " latency"}, lat, special ? 32'd0 : 32'd32);
      chk({name, " result"}, dif.o_result, exp);
      last_res = exp;
      @(negedge clk);
      chk({name, " pulse+ready"}, {30'd0, dif.o_valid, dif.o_ready}, 32'd1);
   endtask

   initial begin
      int  lat;
      bit  got;
      bit  seen;
      vec_cnt  = 0;
      miscmp   = 0;
      last_res = 32'd0;

      vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, "DIVU 100/7"};
      vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0, "REMU 100/7"};
      vecs[2]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0, "DIV -7/2"};
      vecs[3]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0, "REM -7/2"};
      vecs[4]  = '{2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0, "DIV 7/-2"};
      vecs[5]  = '{2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          1'b0, "REM 7/-2"};
      vecs[6]  = '{2'b00, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1, "DIV 5/0"};
      vecs[7]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1, "REMU 5/0"};
      vecs[8]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1, "DIV ovf"};
      vecs[9]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1, "REM ovf"};
      vecs[10] = '{2'b10, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1'b1, "REM -7/0"};
      vecs[11] = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, "DIVU max/max"};
      vecs[12] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          1'b0, "REMU max/max-1"};
      vecs[13] = '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0, "DIVU 2^31/max"};
      vecs[14] = '{2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, "REMU 2^31/max"};
      vecs[15] = '{2'b00, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,          1'b0, "DIV -8/-3"};
      vecs[16] = '{2'b10, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'hFFFFFFFE,   1'b0, "REM -8/-3"};
      vecs[17] = '{2'b00, 32'h80000000,   32'd1,          32'h80000000,   1'b0, "DIV min/1"};

      dif.i_start  = 1'b0;
      dif.i_div_op = 2'b00;
      dif.i_op_a   = 32'd0;
      dif.i_op_b   = 32'd0;
      dif.i_kill   = 1'b0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset ready/valid", {30'd0, dif.o_ready, dif.o_valid}, 32'd2);
      chk("reset result", dif.o_result, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special, vecs[i].name);
      end

      // Re-request with new operands during CALC must be ignored.
      @(negedge clk);
      dif.i_start = 1'b1; dif.i_div_op = 2'b01; dif.i_op_a = 32'd100; dif.i_op_b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      dif.i_start = 1'b0; dif.i_div_op = 2'b11; dif.i_op_a = 32'd1000; dif.i_op_b = 32'd3;
      lat = 0;
      repeat (3) begin @(posedge clk); lat++; end
      @(negedge clk);
      dif.i_start = 1'b1;
      repeat (8) begin @(posedge clk); lat++; end
      @(negedge clk);
      dif.i_start = 1'b0;
      wait_valid(lat, got);
      chk("hazard valid seen", {31'd0, got}, 32'd1);
      chk("hazard latency", lat, 32'd32);
      chk("hazard result", dif.o_result, 32'd14);
      last_res = 32'd14;
      @(negedge clk);

      // Kill at iteration 10.
      dif.i_start = 1'b1; dif.i_div_op = 2'b01; dif.i_op_a = 32'd1000; dif.i_op_b = 32'd3;
      @(posedge clk);
      @(negedge clk);
      dif.i_start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      dif.i_kill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dif.i_kill = 1'b0;
      chk("kill ready/valid", {30'd0, dif.o_ready, dif.o_valid}, 32'd2);
      chk("kill result held", dif.o_result, last_res);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (dif.o_valid === 1'b1) seen = 1'b1;
      end
      chk("kill no valid", {31'd0, seen}, 32'd0);

      // Kill wins over start in IDLE.
      @(negedge clk);
      dif.i_start = 1'b1; dif.i_kill = 1'b1; dif.i_div_op = 2'b01;
      @(posedge clk);
      @(negedge clk);
      dif.i_start = 1'b0; dif.i_kill = 1'b0;
      chk("kill prio ready", {31'd0, dif.o_ready}, 32'd1);

      // Async reset at iteration 20.
      dif.i_start = 1'b1; dif.i_div_op = 2'b01; dif.i_op_a = 32'd100; dif.i_op_b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      dif.i_start = 1'b0;
      repeat (19) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst ready/valid", {30'd0, dif.o_ready, dif.o_valid}, 32'd2);
      chk("async rst result", dif.o_result, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, "DIVU max/1 after reset");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end
endmodule
